// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch stage: opcodes, immediate modifiers
// and the per-opcode operand-usage decode.
package operand_fetch_unit_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam logic [3:0] RA_IDX = 4'd15;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_ZEXT = 2'b01;
  localparam logic [1:0] MOD_HIGH = 2'b10;

  function automatic logic uses_a(input logic [4:0] op);
    case (op)
      OP_NOT, OP_MOV, OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL: uses_a = 1'b0;
      default: uses_a = 1'b1;
    endcase
  endfunction

  function automatic logic uses_b(input logic [4:0] op, input logic ior);
    uses_b = !ior && ((op <= OP_ASR) || (op == OP_LD) || (op == OP_ST));
  endfunction

  // cmp only updates flags in execute, so it never claims a destination.
  function automatic logic writes_rd(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOT, OP_MOV,
      OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_CALL: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] imm_expand(input logic [15:0] imm,
                                                   input logic [1:0] modifier);
    case (modifier)
      MOD_ZEXT: imm_expand = {16'h0000, imm};
      MOD_HIGH: imm_expand = {imm, 16'h0000};
      default:  imm_expand = {{16{imm[15]}}, imm};
    endcase
  endfunction

endpackage

// File: rtl/operand_fetch_unit_regfile.sv
// Architectural register file: three asynchronous read ports, one synchronous
// write port, cleared by reset. Bypassing is done by the caller.
module operand_fetch_unit_regfile
  import operand_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [3:0]        i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic [3:0]        i_rc_addr,
  output logic [DATA_W-1:0] o_rc_data,
  input  logic              i_we,
  input  logic [3:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= {DATA_W{1'b0}};
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_ra_data = r_regs[i_ra_addr];
  assign o_rb_data = r_regs[i_rb_addr];
  assign o_rc_data = r_regs[i_rc_addr];

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: register read with writeback bypass, busy scoreboard for
// RAW/WAW hazards, and a registered valid/ready bundle towards execute.
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_opcode,
  input  logic        in_iOrReg,
  input  logic [15:0] in_imm,
  input  logic [1:0]  in_modifier,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_branch_target,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_branch_target,
  output logic [4:0]  out_opcode,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  output logic [31:0] out_store_val,
  output logic [3:0]  out_rd,
  output logic        out_wr_en
);

  logic [NREGS-1:0]  r_busy;
  logic              r_out_valid;
  logic [31:0]       r_out_pc, r_out_bt, r_out_op_a, r_out_op_b, r_out_st;
  logic [4:0]        r_out_opcode;
  logic [3:0]        r_out_rd;
  logic              r_out_wr_en;

  logic [3:0]        w_src_a, w_dest;
  logic              w_use_a, w_use_b, w_use_st, w_wr;
  logic [DATA_W-1:0] w_rf_a, w_rf_b, w_rf_st;
  logic [DATA_W-1:0] w_a_val, w_b_val, w_st_val;
  logic [NREGS-1:0]  w_blocked, w_busy_nxt;
  logic              w_hazard, w_accept, w_issue, w_in_ready;

  assign w_src_a  = (in_opcode == OP_RET) ? RA_IDX : in_rs1;
  assign w_dest   = (in_opcode == OP_CALL) ? RA_IDX : in_rd;
  assign w_use_a  = uses_a(in_opcode);
  assign w_use_b  = uses_b(in_opcode, in_iOrReg);
  assign w_use_st = (in_opcode == OP_ST);
  assign w_wr     = writes_rd(in_opcode);

  operand_fetch_unit_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_ra_addr (w_src_a),
    .o_ra_data (w_rf_a),
    .i_rb_addr (in_rs2),
    .o_rb_data (w_rf_b),
    .i_rc_addr (in_rd),
    .o_rc_data (w_rf_st),
    .i_we      (wb_en),
    .i_wa      (wb_addr),
    .i_wd      (wb_data)
  );

  assign w_a_val  = (wb_en && wb_addr == w_src_a) ? wb_data : w_rf_a;
  assign w_b_val  = (wb_en && wb_addr == in_rs2)  ? wb_data : w_rf_b;
  assign w_st_val = (wb_en && wb_addr == in_rd)   ? wb_data : w_rf_st;

  // A register is blocked while an older producer is outstanding, unless its
  // result arrives on the writeback port this very cycle.
  always_comb begin
    w_blocked  = {NREGS{1'b0}};
    w_busy_nxt = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      w_blocked[i]  = (r_busy[i] && !(wb_en && wb_addr == 4'(i)))
                   || (r_out_valid && r_out_wr_en && r_out_rd == 4'(i));
      w_busy_nxt[i] = (w_issue && r_out_wr_en && r_out_rd == 4'(i))
                   || (r_busy[i] && !(wb_en && wb_addr == 4'(i)));
    end
  end

  assign w_hazard = (w_use_a  && w_blocked[w_src_a])
                 || (w_use_b  && w_blocked[in_rs2])
                 || (w_use_st && w_blocked[in_rd])
                 || (w_wr     && w_blocked[w_dest]);

  assign w_in_ready = reset && !flush && !w_hazard && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_issue    = r_out_valid && out_ready && !flush;

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!reset) r_busy <= {NREGS{1'b0}};
    else        r_busy <= w_busy_nxt;
  end

  // Output bundle register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out_pc     <= 32'h0;
      r_out_bt     <= 32'h0;
      r_out_opcode <= 5'd0;
      r_out_op_a   <= 32'h0;
      r_out_op_b   <= 32'h0;
      r_out_st     <= 32'h0;
      r_out_rd     <= 4'd0;
      r_out_wr_en  <= 1'b0;
    end else begin
      if (flush)         r_out_valid <= 1'b0;
      else if (w_accept) r_out_valid <= 1'b1;
      else if (w_issue)  r_out_valid <= 1'b0;
      else               r_out_valid <= r_out_valid;
      if (w_accept) begin
        r_out_pc     <= in_pc;
        r_out_bt     <= in_branch_target;
        r_out_opcode <= in_opcode;
        r_out_op_a   <= w_use_a ? w_a_val : 32'h0;
        r_out_op_b   <= w_use_b ? w_b_val : imm_expand(in_imm, in_modifier);
        r_out_st     <= w_use_st ? w_st_val : 32'h0;
        r_out_rd     <= w_dest;
        r_out_wr_en  <= w_wr;
      end
    end
  end

  assign in_ready          = w_in_ready;
  assign out_valid         = r_out_valid;
  assign out_pc            = r_out_pc;
  assign out_branch_target = r_out_bt;
  assign out_opcode        = r_out_opcode;
  assign out_op_a          = r_out_op_a;
  assign out_op_b          = r_out_op_b;
  assign out_store_val     = r_out_st;
  assign out_rd            = r_out_rd;
  assign out_wr_en         = r_out_wr_en;

endmodule
